// File: rtl/instr_sequencer.sv
// Multi-cycle CPU control sequencer: fetch with ROM handshake/timeout, decode, execute, write-back, halt.
// Optional SEQ_SINGLE_STEP_EN: return to IDLE after every instruction instead of fetching the next one.
module instr_sequencer #(
  parameter int unsigned PC_WIDTH = 3,
  parameter int unsigned MAX_WAIT = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          opcode,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                zero_flag,
  input  logic                rom_ready,
  output logic [PC_WIDTH-1:0] pc,
  output logic                rom_read_enable,
  output logic                ir_load,
  output logic                alu_enable,
  output logic                reg_write,
  output logic [2:0]          state,
  output logic                halted,
  output logic                timeout_err
);

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ALU = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_JMP = 3'b011;
  localparam logic [2:0] OP_BZ  = 3'b100;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT      = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t S_AFTER = S_IDLE;
`else
  localparam state_t S_AFTER = S_FETCH;
`endif

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                tmo_q, tmo_d;

  assign pc_inc      = pc_q + PC_WIDTH'(1);
  assign pc          = pc_q;
  assign state       = state_q;
  assign timeout_err = tmo_q;

  // State and datapath-control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state, PC update and strobe decode
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    tmo_d           = tmo_q;
    rom_read_enable = 1'b0;
    ir_load         = 1'b0;
    alu_enable      = 1'b0;
    reg_write       = 1'b0;
    halted          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        rom_read_enable = 1'b1;
        if (rom_ready) begin
          ir_load = 1'b1;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rom_read_enable = 1'b1;
        if (rom_ready) begin
          ir_load = 1'b1;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
          tmo_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        op_d    = opcode;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_enable = (op_q == OP_ALU);
        case (op_q)
          OP_ALU, OP_LDI: begin
            pc_d    = pc_inc;
            state_d = S_WRITEBACK;
          end
          OP_JMP: begin
            pc_d    = branch_target;
            state_d = S_AFTER;
          end
          OP_BZ: begin
            pc_d    = zero_flag ? branch_target : pc_inc;
            state_d = S_AFTER;
          end
          OP_HLT: begin
            state_d = S_HALT;
          end
          default: begin
            pc_d    = pc_inc;
            state_d = S_AFTER;
          end
        endcase
      end
      S_WRITEBACK: begin
        reg_write = 1'b1;
        state_d   = S_AFTER;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: instruction-level reference model with randomized traffic.
module tb_instr_sequencer;

  localparam int unsigned PW    = 3;
  localparam int unsigned MAXW  = 7;
  localparam int          PCMOD = 1 << PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    opcode;
  logic [PW-1:0] branch_target;
  logic          zero_flag;
  logic          rom_ready;
  logic [PW-1:0] pc;
  logic          rom_read_enable, ir_load, alu_enable, reg_write, halted, timeout_err;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;
  int m_pc  = 0;
  bit m_tmo = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  instr_sequencer #(.PC_WIDTH(PW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .branch_target(branch_target), .zero_flag(zero_flag), .rom_ready(rom_ready),
    .pc(pc), .rom_read_enable(rom_read_enable), .ir_load(ir_load),
    .alu_enable(alu_enable), .reg_write(reg_write), .state(state),
    .halted(halted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobes follow from the expected state; ir_load additionally needs rom_ready.
  task automatic chk_outputs(input string tag, input int e_st, input bit e_ir, input bit e_alu);
    chk({tag, ".state"}, 32'(state), 32'(e_st));
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".rre"}, 32'(rom_read_enable), 32'(e_st == 1 || e_st == 2));
    chk({tag, ".ir_load"}, 32'(ir_load), 32'(e_ir));
    chk({tag, ".alu_en"}, 32'(alu_enable), 32'(e_alu));
    chk({tag, ".reg_wr"}, 32'(reg_write), 32'(e_st == 5));
    chk({tag, ".halted"}, 32'(halted), 32'(e_st == 6));
    chk({tag, ".tmo"}, 32'(timeout_err), 32'(m_tmo));
  endtask

  task automatic cyc(input string tag, input bit s, input logic [2:0] op,
                     input logic [PW-1:0] tgt, input bit zf, input bit rr,
                     input int e_st, input bit e_ir, input bit e_alu);
    @(negedge clk);
    start = s; opcode = op; branch_target = tgt; zero_flag = zf; rom_ready = rr;
    #1;
    chk_outputs(tag, e_st, e_ir, e_alu);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    m_pc  = 0;
    m_tmo = 1'b0;
    chk_outputs(tag, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic launch();
    cyc("idle_start", 1'b1, 3'($urandom), PW'($urandom), rb(), rb(), 0, 1'b0, 1'b0);
  endtask

  // One instruction: nwait WAIT cycles, rom_ready rising in the last of them.
  task automatic do_instr(input logic [2:0] op, input logic [PW-1:0] tgt, input bit zf, input int nwait);
    cyc("fetch", rb(), 3'($urandom), PW'($urandom), rb(), nwait == 0, 1, nwait == 0, 1'b0);
    for (int i = 1; i <= nwait; i++)
      cyc("wait", rb(), 3'($urandom), PW'($urandom), rb(), i == nwait, 2, i == nwait, 1'b0);
    cyc("decode", rb(), op, PW'($urandom), rb(), rb(), 3, 1'b0, 1'b0);
    cyc("execute", rb(), 3'($urandom), tgt, zf, rb(), 4, 1'b0, op == 3'b001);
    case (op)
      3'b011:  m_pc = int'(tgt);
      3'b100:  m_pc = zf ? int'(tgt) : (m_pc + 1) % PCMOD;
      3'b111:  m_pc = m_pc;
      default: m_pc = (m_pc + 1) % PCMOD;
    endcase
    if (op == 3'b001 || op == 3'b010)
      cyc("writeback", rb(), 3'($urandom), PW'($urandom), rb(), rb(), 5, 1'b0, 1'b0);
    if (SS && op != 3'b111) begin
      cyc("ss_idle", 1'b0, 3'($urandom), PW'($urandom), rb(), rb(), 0, 1'b0, 1'b0);
      launch();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 3'b000; branch_target = '0;
    zero_flag = 1'b0; rom_ready = 1'b0;
    #3;
    chk_outputs("por", 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc("idle_hold", 1'b0, 3'b000, '0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    launch();

    // Directed instruction mix, including branches and the 7->0 wrap.
    do_instr(3'b000, 3'd0, 1'b0, 0);
    do_instr(3'b000, 3'd0, 1'b0, 0);
    do_instr(3'b100, 3'd5, 1'b1, 0);
    do_instr(3'b011, 3'd2, 1'b0, 0);
    do_instr(3'b100, 3'd5, 1'b0, 0);
    do_instr(3'b011, 3'd6, 1'b1, 0);
    do_instr(3'b001, 3'd3, 1'b0, 0);
    do_instr(3'b001, 3'd3, 1'b1, 0);
    chk("wrap_pc", 32'(m_pc), 32'd0);
    do_instr(3'b010, 3'd4, 1'b0, 0);
    do_instr(3'b000, 3'd4, 1'b0, 3);
    do_instr(3'b101, 3'd1, 1'b1, 1);
    do_instr(3'b110, 3'd1, 1'b1, MAXW);

    // Randomized traffic, HLT excluded so execution keeps going.
    for (int n = 0; n < 40; n++) begin
      int w;
      w = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, MAXW));
      do_instr(3'($urandom_range(0, 6)), PW'($urandom), rb(), w);
    end

    // HLT at pc=4 freezes pc and ignores start.
    do_instr(3'b011, 3'd4, 1'b0, 0);
    do_instr(3'b111, 3'd1, 1'b1, 0);
    for (int i = 0; i < 4; i++)
      cyc("halt", 1'b1, 3'($urandom), PW'($urandom), rb(), rb(), 6, 1'b0, 1'b0);
    async_reset("rst_halt");

    // Reset in the middle of WAIT.
    launch();
    cyc("mw_fetch", 1'b0, 3'b000, '0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    cyc("mw_wait", 1'b0, 3'b000, '0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    async_reset("rst_wait");

    // Reset in the middle of EXECUTE, after pc has already advanced once.
    launch();
    do_instr(3'b000, 3'd0, 1'b0, 0);
    cyc("me_fetch", 1'b0, 3'b000, '0, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    cyc("me_decode", 1'b0, 3'b001, '0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    cyc("me_execute", 1'b0, 3'b000, '0, 1'b0, 1'b0, 4, 1'b0, 1'b1);
    async_reset("rst_exec");

    // ROM never ready: MAX_WAIT WAIT cycles then sticky timeout and HALT.
    launch();
    cyc("to_fetch", 1'b0, 3'b000, '0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    for (int i = 1; i <= MAXW; i++)
      cyc("to_wait", rb(), 3'($urandom), PW'($urandom), rb(), 1'b0, 2, 1'b0, 1'b0);
    m_tmo = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("to_halt", 1'b1, 3'($urandom), PW'($urandom), rb(), rb(), 6, 1'b0, 1'b0);
    async_reset("rst_tmo");
    cyc("post_idle", 1'b0, 3'b000, '0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control unit that sequences the CPU datapath: program counter, instruction ROM read, instruction register load, ALU enable and register write-back. It extends the basic fetch/decode/execute loop with a ROM ready handshake and wait timeout, jump and branch-on-zero, a write-back phase and a halt state. It sits between the instruction ROM/IR and the ALU/register file. It is the single owner of the PC.

Parameters:
PC_WIDTH, 3, width of the program counter; wraps modulo 2^PC_WIDTH.
MAX_WAIT, 7, maximum number of WAIT cycles without rom_ready before timeout; range 1..15.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  launch pulse; sampled only in IDLE.
opcode  input  3  instruction opcode from the IR; sampled in DECODE.
branch_target  input  PC_WIDTH  jump/branch destination; sampled in EXECUTE.
zero_flag  input  1  ALU zero flag; sampled in EXECUTE.
rom_ready  input  1  ROM data valid this cycle.
pc  output  PC_WIDTH  program counter (registered).
rom_read_enable  output  1  ROM read strobe.
ir_load  output  1  IR capture strobe.
alu_enable  output  1  ALU operate strobe.
reg_write  output  1  register-file write strobe.
state  output  3  current state encoding (registered).
halted  output  1  high while in HALT.
timeout_err  output  1  sticky; ROM wait timeout occurred.

Behaviour:
- State encodings: IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXECUTE=4, WRITEBACK=5, HALT=6. Encoding 7 is illegal and goes to HALT next cycle.
- Reset (asynchronous, takes effect immediately, including mid-instruction):
  - state=IDLE, pc=0, wait counter=0, latched opcode=000.
  - All strobes 0; halted=0; timeout_err=0.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: rom_read_enable=1.
  - rom_ready=1 -> ir_load=1 in the same cycle; next state DECODE.
  - rom_ready=0 -> WAIT; wait counter=1.
- WAIT: rom_read_enable=1.
  - rom_ready=1 -> ir_load=1; next state DECODE; wait counter cleared.
  - rom_ready=0 with counter==MAX_WAIT -> timeout_err=1; next state HALT.
  - rom_ready=0 otherwise -> counter+1; stay in WAIT.
- ir_load is Mealy: ir_load = (state==FETCH or state==WAIT) and rom_ready. All other strobes are Moore, decoded from state.
- DECODE: latch opcode; next state EXECUTE. No strobes.
- EXECUTE: alu_enable=1 only for opcode ALU. Opcode actions:
  - 000 NOP: pc+1 -> FETCH.
  - 001 ALU: pc+1 -> WRITEBACK.
  - 010 LDI: pc+1 -> WRITEBACK.
  - 011 JMP: pc=branch_target -> FETCH.
  - 100 BZ: pc = zero_flag ? branch_target : pc+1 -> FETCH.
  - 111 HLT: pc unchanged -> HALT.
  - 101 and 110 behave as NOP.
- WRITEBACK: reg_write=1 for exactly one cycle; next state FETCH.
- HALT: halted=1; all strobes 0; pc frozen; start ignored. Only reset exits HALT.
- PC arithmetic: pc+1 wraps from 2^PC_WIDTH-1 to 0 with no flag.
- start outside IDLE is ignored.
- Instruction latency from FETCH entry with rom_ready=1: 3 cycles (NOP/JMP/BZ) or 4 cycles (ALU/LDI).

Optional Feature:
SEQ_SINGLE_STEP_EN
- Defined: every transition that would go EXECUTE->FETCH or WRITEBACK->FETCH goes to IDLE instead. Each instruction then needs a new start pulse. pc is already updated when IDLE is entered.
- Undefined: continuous execution as described above; IDLE is only left once, after reset.

Test Plan:
- Reset, start=1 for 1 cycle, rom_ready=1 always, opcode=000 -> state sequence 0,1,3,4,1,...; pc steps 0->1->2 every 3 cycles; ir_load pulses in each FETCH.
- opcode=001 with rom_ready=1 -> alu_enable=1 in EXECUTE, reg_write=1 in WRITEBACK for exactly 1 cycle each; 4-cycle period; pc 7->0 wrap observed.
- opcode=100, branch_target=5: zero_flag=1 -> pc=5; zero_flag=0 at pc=2 -> pc=3. opcode=011, branch_target=6 -> pc=6.
- rom_ready low for 3 cycles then high -> WAIT held 3 cycles, ir_load coincides with rom_ready, timeout_err stays 0. rom_ready held low -> after MAX_WAIT=7 WAIT cycles, timeout_err=1, state=6, halted=1.
- opcode=111 at pc=4 -> HALT with pc=4; start pulses ignored. Reset asserted mid-WAIT and mid-EXECUTE -> immediate state=0, pc=0, all outputs 0.
- With SEQ_SINGLE_STEP_EN: one start pulse, opcode=000 -> exactly one instruction executes, state returns to 0, pc=1; a second start pulse -> pc=2.
